// File: rtl/pcpi_lockstep_checker.sv
// Lockstep checker: compares a golden PCPI response against a DUT response and passes the golden one through.
// Optional macro PCPI_CHK_HALT_EN adds chk_halt, which stalls the core once a mismatch has been seen.
module pcpi_lockstep_checker #(
  parameter int XLEN    = 32,
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             chk_en,
  input  logic             chk_clear,
  input  logic             gold_ready,
  input  logic             gold_wait,
  input  logic [XLEN-1:0]  gold_rd,
  input  logic             gold_wr,
  input  logic             dut_ready,
  input  logic             dut_wait,
  input  logic [XLEN-1:0]  dut_rd,
  input  logic             dut_wr,
  output logic             pcpi_int_ready,
  output logic             pcpi_int_wait,
  output logic [XLEN-1:0]  pcpi_int_rd,
  output logic             pcpi_int_wr,
  output logic             mismatch,
  output logic [3:0]       mismatch_fields,
  output logic             err_sticky,
  output logic [3:0]       err_fields,
  output logic [3:0]       first_fields,
  output logic [CNT_W-1:0] first_cycle,
  output logic [CNT_W-1:0] err_count
`ifdef PCPI_CHK_HALT_EN
  , output logic           chk_halt
`endif
);

  localparam int PW = XLEN + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]    gold_vec;
  logic [PW-1:0]    g_vec;
  logic             pipe_full;
  logic             g_ready, g_wait, g_wr;
  logic [XLEN-1:0]  g_rd;
  logic             cmp;
  logic [3:0]       fields_d;
  logic             hit;

  logic             mismatch_q;
  logic [3:0]       mismatch_fields_q;
  logic             err_sticky_q;
  logic [3:0]       err_fields_q;
  logic [3:0]       first_fields_q;
  logic [CNT_W-1:0] first_cycle_q;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] cycle_q;

  assign gold_vec = {gold_ready, gold_wait, gold_rd, gold_wr};

  // Golden alignment chain plus warm-up valid shift register
  if (DUT_LAT == 0) begin : g_direct
    assign g_vec     = gold_vec;
    assign pipe_full = 1'b1;
  end else begin : g_delay
    logic [PW-1:0]      align_q [DUT_LAT];
    logic [DUT_LAT-1:0] vld_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < DUT_LAT; i++) align_q[i] <= '0;
        vld_q <= '0;
      end else begin
        align_q[0] <= gold_vec;
        vld_q[0]   <= 1'b1;
        for (int i = 1; i < DUT_LAT; i++) begin
          align_q[i] <= align_q[i-1];
          vld_q[i]   <= vld_q[i-1];
        end
      end
    end

    assign g_vec     = align_q[DUT_LAT-1];
    assign pipe_full = vld_q[DUT_LAT-1];
  end

  assign g_ready = g_vec[PW-1];
  assign g_wait  = g_vec[PW-2];
  assign g_rd    = g_vec[XLEN:1];
  assign g_wr    = g_vec[0];

  // wr only matters on a ready handshake; rd only when both sides write back
  assign cmp      = chk_en & pipe_full;
  assign fields_d = {g_ready != dut_ready,
                     g_wait != dut_wait,
                     g_ready & g_wr & dut_ready & dut_wr & (g_rd != dut_rd),
                     g_ready & (g_wr != dut_wr)};
  assign hit      = cmp & (|fields_d);

  // Diagnostics stage: clear has priority over a same-cycle mismatch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_q           <= '0;
      mismatch_q        <= 1'b0;
      mismatch_fields_q <= '0;
      err_sticky_q      <= 1'b0;
      err_fields_q      <= '0;
      first_fields_q    <= '0;
      first_cycle_q     <= '0;
      err_count_q       <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (chk_clear) begin
        mismatch_q        <= 1'b0;
        mismatch_fields_q <= '0;
        err_sticky_q      <= 1'b0;
        err_fields_q      <= '0;
        first_fields_q    <= '0;
        first_cycle_q     <= '0;
        err_count_q       <= '0;
      end else begin
        mismatch_q        <= hit;
        mismatch_fields_q <= cmp ? fields_d : 4'b0000;
        if (hit) begin
          if (!err_sticky_q) begin
            first_fields_q <= fields_d;
            first_cycle_q  <= cycle_q;
          end
          err_sticky_q <= 1'b1;
          err_fields_q <= err_fields_q | fields_d;
          if (err_count_q != CNT_MAX) err_count_q <= err_count_q + CNT_W'(1);
        end
      end
    end
  end

  assign mismatch        = mismatch_q;
  assign mismatch_fields = mismatch_fields_q;
  assign err_sticky      = err_sticky_q;
  assign err_fields      = err_fields_q;
  assign first_fields    = first_fields_q;
  assign first_cycle     = first_cycle_q;
  assign err_count       = err_count_q;

`ifdef PCPI_CHK_HALT_EN
  logic chk_halt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) chk_halt_q <= 1'b0;
    else         chk_halt_q <= chk_clear ? 1'b0 : err_sticky_q;
  end

  // Halted core sees an endless wait with no writeback
  assign chk_halt       = chk_halt_q;
  assign pcpi_int_ready = gold_ready & ~chk_halt_q;
  assign pcpi_int_wait  = gold_wait | chk_halt_q;
  assign pcpi_int_rd    = chk_halt_q ? '0 : gold_rd;
  assign pcpi_int_wr    = gold_wr & ~chk_halt_q;
`else
  assign pcpi_int_ready = gold_ready;
  assign pcpi_int_wait  = gold_wait;
  assign pcpi_int_rd    = gold_rd;
  assign pcpi_int_wr    = gold_wr;
`endif

endmodule

// File: tb/tb_pcpi_lockstep_checker.sv
// Randomized bench for pcpi_lockstep_checker: two instances (DUT_LAT=0/CNT_W=16 and DUT_LAT=2/CNT_W=4)
// checked every cycle against a cycle-indexed reference model built from the checker's rules.
module tb_pcpi_lockstep_checker;

  localparam int NCYC = 1200;

  typedef struct packed {
    logic        rdy;
    logic        wt;
    logic [31:0] rd;
    logic        wr;
  } rsp_t;

  typedef struct {
    bit       sticky;
    bit       mm;
    bit [3:0] mmf;
    bit [3:0] fields;
    bit [3:0] ffirst;
    int       fcyc;
    int       cnt;
    bit       halt;
  } mst_t;

  logic        clk = 1'b0;
  logic        resetn, chk_en, chk_clear;
  logic        gold_ready, gold_wait, gold_wr;
  logic [31:0] gold_rd;
  logic        d0_ready, d0_wait, d0_wr, d2_ready, d2_wait, d2_wr;
  logic [31:0] d0_rd, d2_rd;

  logic        o0_ready, o0_wait, o0_wr, o2_ready, o2_wait, o2_wr;
  logic [31:0] o0_rd, o2_rd;
  logic        mm0, st0, mm2, st2;
  logic [3:0]  mmf0, ef0, ff0, mmf2, ef2, ff2;
  logic [15:0] fc0, ec0;
  logic [3:0]  fc2, ec2;
`ifdef PCPI_CHK_HALT_EN
  logic        halt0, halt2;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int cur_k = -1;

  always #5 clk = ~clk;

  pcpi_lockstep_checker #(.XLEN(32), .DUT_LAT(0), .CNT_W(16)) u0 (
    .clk(clk), .resetn(resetn), .chk_en(chk_en), .chk_clear(chk_clear),
    .gold_ready(gold_ready), .gold_wait(gold_wait), .gold_rd(gold_rd), .gold_wr(gold_wr),
    .dut_ready(d0_ready), .dut_wait(d0_wait), .dut_rd(d0_rd), .dut_wr(d0_wr),
    .pcpi_int_ready(o0_ready), .pcpi_int_wait(o0_wait), .pcpi_int_rd(o0_rd), .pcpi_int_wr(o0_wr),
    .mismatch(mm0), .mismatch_fields(mmf0), .err_sticky(st0), .err_fields(ef0),
    .first_fields(ff0), .first_cycle(fc0), .err_count(ec0)
`ifdef PCPI_CHK_HALT_EN
    , .chk_halt(halt0)
`endif
  );

  pcpi_lockstep_checker #(.XLEN(32), .DUT_LAT(2), .CNT_W(4)) u2 (
    .clk(clk), .resetn(resetn), .chk_en(chk_en), .chk_clear(chk_clear),
    .gold_ready(gold_ready), .gold_wait(gold_wait), .gold_rd(gold_rd), .gold_wr(gold_wr),
    .dut_ready(d2_ready), .dut_wait(d2_wait), .dut_rd(d2_rd), .dut_wr(d2_wr),
    .pcpi_int_ready(o2_ready), .pcpi_int_wait(o2_wait), .pcpi_int_rd(o2_rd), .pcpi_int_wr(o2_wr),
    .mismatch(mm2), .mismatch_fields(mmf2), .err_sticky(st2), .err_fields(ef2),
    .first_fields(ff2), .first_cycle(fc2), .err_count(ec2)
`ifdef PCPI_CHK_HALT_EN
    , .chk_halt(halt2)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cur_k, obs, exp);
  endtask

  // Reference: one clock of the checker, in terms of the aligned golden response for this cycle
  function automatic mst_t model_step(mst_t s, int lat, int cw, int k, bit en, bit clr,
                                      rsp_t g, rsp_t d);
    mst_t     n = s;
    bit [3:0] f;
    bit       cmp = en && (k >= lat);
    f[3] = (g.rdy != d.rdy);
    f[2] = (g.wt != d.wt);
    f[1] = g.rdy && g.wr && d.rdy && d.wr && (g.rd != d.rd);
    f[0] = g.rdy && (g.wr != d.wr);
    n.halt = clr ? 1'b0 : s.sticky;
    if (clr) begin
      n.sticky = 0; n.mm = 0; n.mmf = 0; n.fields = 0; n.ffirst = 0; n.fcyc = 0; n.cnt = 0;
    end else begin
      n.mm  = cmp && (f != 0);
      n.mmf = cmp ? f : 4'b0;
      if (n.mm) begin
        if (!s.sticky) begin
          n.ffirst = f;
          n.fcyc   = k % (1 << cw);
        end
        n.sticky = 1;
        n.fields = s.fields | f;
        if (s.cnt < (1 << cw) - 1) n.cnt = s.cnt + 1;
      end
    end
    return n;
  endfunction

  function automatic rsp_t corrupt(rsp_t r);
    rsp_t c = r;
    case ($urandom_range(0, 3))
      0: c.rdy = ~c.rdy;
      1: c.wt  = ~c.wt;
      2: c.rd  = c.rd ^ ($urandom | 32'h1);
      default: c.wr = ~c.wr;
    endcase
    return c;
  endfunction

  task automatic check_regs(input string p, input mst_t s, input logic mm, input logic [3:0] mmf,
                            input logic st, input logic [3:0] ef, input logic [3:0] ff,
                            input logic [15:0] fc, input logic [15:0] ec);
    check_eq({p, ".mismatch"}, 64'(mm), 64'(s.mm));
    check_eq({p, ".mismatch_fields"}, 64'(mmf), 64'(s.mmf));
    check_eq({p, ".err_sticky"}, 64'(st), 64'(s.sticky));
    check_eq({p, ".err_fields"}, 64'(ef), 64'(s.fields));
    check_eq({p, ".first_fields"}, 64'(ff), 64'(s.ffirst));
    check_eq({p, ".first_cycle"}, 64'(fc), 64'(s.fcyc));
    check_eq({p, ".err_count"}, 64'(ec), 64'(s.cnt));
  endtask

  task automatic check_pass(input string p, input bit halt, input rsp_t g,
                            input logic r, input logic w, input logic [31:0] rd, input logic wr);
    rsp_t e = g;
`ifdef PCPI_CHK_HALT_EN
    if (halt) e = '{rdy: 1'b0, wt: 1'b1, rd: 32'h0, wr: 1'b0};
`endif
    check_eq({p, ".pcpi_int_ready"}, 64'(r), 64'(e.rdy));
    check_eq({p, ".pcpi_int_wait"}, 64'(w), 64'(e.wt));
    check_eq({p, ".pcpi_int_rd"}, 64'(rd), 64'(e.rd));
    check_eq({p, ".pcpi_int_wr"}, 64'(wr), 64'(e.wr));
  endtask

  initial begin
    rsp_t ghist [NCYC];
    rsp_t gcur, g2al, d0, d2;
    mst_t s0, s2, zero;
    bit   en, clr;

    zero = '{default: 0};
    s0 = zero;
    s2 = zero;
    resetn = 1'b0; chk_en = 1'b0; chk_clear = 1'b0;
    {gold_ready, gold_wait, gold_rd, gold_wr} = '0;
    {d0_ready, d0_wait, d0_rd, d0_wr} = '0;
    {d2_ready, d2_wait, d2_rd, d2_wr} = '0;
    repeat (3) @(negedge clk);
    check_regs("rst.u0", zero, mm0, mmf0, st0, ef0, ff0, fc0, ec0);
    check_regs("rst.u2", zero, mm2, mmf2, st2, ef2, ff2, {12'h0, fc2}, {12'h0, ec2});
    resetn = 1'b1;

    for (int k = 0; k < NCYC; k++) begin
      cur_k = k;
      en = 1'b1;
      clr = 1'b0;
      gcur.rdy = 1'($urandom_range(0, 1));
      gcur.wt  = ($urandom_range(0, 3) == 0);
      gcur.rd  = $urandom;
      gcur.wr  = 1'($urandom_range(0, 1));
      if (k < 100 && k % 7 == 0) gcur = '{rdy: 1'b1, wt: 1'b0, rd: 32'hDEADBEEF, wr: 1'b1};
      if (k == 20) gcur = '{rdy: 1'b1, wt: 1'b0, rd: 32'h12345678, wr: 1'b1};
      if (k > 20 && k <= 40) gcur.rdy = 1'b0;
      ghist[k] = gcur;
      g2al = (k >= 2) ? ghist[k-2] : '0;
      d0 = gcur;
      d2 = g2al;

      if (k == 20) d0.rd = 32'h12345679;
      if (k > 20 && k < 40) begin
        d0.wr = ~gcur.wr;
        d0.rd = ~gcur.rd;
      end
      if (k == 40) d0.wt = ~gcur.wt;
      if (k >= 60 && k < 80) d2 = ghist[k-1];
      if (k >= 100 && k < 120) d2.rdy = ~g2al.rdy;
      if (k == 120) begin
        clr = 1'b1;
        d2.rdy = ~g2al.rdy;
        d0.rdy = ~gcur.rdy;
      end
      if (k >= 130 && k < 140) begin
        en = 1'b0;
        d0 = corrupt(gcur);
        d2 = corrupt(g2al);
      end
      if (k >= 200) begin
        en  = ($urandom_range(0, 9) != 0);
        clr = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 99) < 15) d0 = corrupt(gcur);
        if ($urandom_range(0, 99) < 10) d2 = corrupt(g2al);
      end

      chk_en = en;
      chk_clear = clr;
      {gold_ready, gold_wait, gold_rd, gold_wr} = gcur;
      {d0_ready, d0_wait, d0_rd, d0_wr} = d0;
      {d2_ready, d2_wait, d2_rd, d2_wr} = d2;
      #1;
      check_pass("u0", s0.halt, gcur, o0_ready, o0_wait, o0_rd, o0_wr);
      check_pass("u2", s2.halt, gcur, o2_ready, o2_wait, o2_rd, o2_wr);
`ifdef PCPI_CHK_HALT_EN
      check_eq("u0.chk_halt", 64'(halt0), 64'(s0.halt));
      check_eq("u2.chk_halt", 64'(halt2), 64'(s2.halt));
`endif

      s0 = model_step(s0, 0, 16, k, en, clr, gcur, d0);
      s2 = model_step(s2, 2, 4, k, en, clr, g2al, d2);
      @(negedge clk);
      check_regs("u0", s0, mm0, mmf0, st0, ef0, ff0, fc0, ec0);
      check_regs("u2", s2, mm2, mmf2, st2, ef2, ff2, {12'h0, fc2}, {12'h0, ec2});

      if (k == 19) check_eq("clean.err_count", 64'(ec0), 64'd0);
      if (k == 20) begin
        check_eq("rd.mismatch_fields", 64'(mmf0), 64'h2);
        check_eq("rd.first_cycle", 64'(fc0), 64'd20);
        check_eq("rd.err_count", 64'(ec0), 64'd1);
      end
      if (k == 39) check_eq("unready.err_count", 64'(ec0), 64'd1);
      if (k == 40) check_eq("wait.mismatch_fields", 64'(mmf0), 64'h4);
      if (k == 59) check_eq("lat2.err_sticky", 64'(st2), 64'd0);
      if (k == 119) check_eq("sat.err_count", 64'(ec2), 64'hF);
      if (k == 120) begin
        check_eq("clr.err_count", 64'(ec2), 64'd0);
        check_eq("clr.mismatch", 64'(mm0), 64'd0);
        check_eq("clr.err_sticky", 64'(st0), 64'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pcpi_lockstep_checker.md
Name: pcpi_lockstep_checker

Overview:
Parametrised lockstep checker for PCPI co-processor response interfaces. Compares a golden (hand-written) PCPI response against a generated DUT response, with optional latency alignment. Passes the golden response through to the core. Records mismatches in registered, sticky and counting diagnostics. Used in co-simulation and emulation harnesses around the PCPI interface.

Parameters:
XLEN, 32, width of pcpi_rd data
DUT_LAT, 0, extra cycles of DUT latency vs golden (0..3); golden side delayed by DUT_LAT before compare
CNT_W, 16, width of cycle counter, first-mismatch timestamp and error counter

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
chk_en  in  1  compare enable; low = no compare, diagnostics hold
chk_clear  in  1  synchronous clear of sticky diagnostics and counters
gold_ready  in  1  golden pcpi_int_ready
gold_wait  in  1  golden pcpi_int_wait
gold_rd  in  XLEN  golden pcpi_int_rd
gold_wr  in  1  golden pcpi_int_wr
dut_ready  in  1  DUT pcpi_int_ready
dut_wait  in  1  DUT pcpi_int_wait
dut_rd  in  XLEN  DUT pcpi_int_rd
dut_wr  in  1  DUT pcpi_int_wr
pcpi_int_ready  out  1  pass-through of gold_ready (combinational, undelayed)
pcpi_int_wait  out  1  pass-through of gold_wait
pcpi_int_rd  out  XLEN  pass-through of gold_rd
pcpi_int_wr  out  1  pass-through of gold_wr
mismatch  out  1  registered: mismatch detected in previous compare cycle
mismatch_fields  out  4  registered per-field flags {ready,wait,rd,wr} for that cycle
err_sticky  out  1  set on first mismatch, held until clear
err_fields  out  4  sticky OR of mismatch_fields
first_fields  out  4  mismatch_fields of first mismatch
first_cycle  out  CNT_W  cycle_count value at first mismatch
err_count  out  CNT_W  mismatching compare cycles, saturating

Behaviour:
- Reset (resetn low, async): all registered outputs 0; alignment pipeline, valid pipeline and cycle_count 0.
- Alignment: golden {ready,wait,rd,wr} through DUT_LAT-stage register chain (DUT_LAT=0: direct). DUT side never delayed.
- Warm-up: DUT_LAT-bit valid shift reg fills with 1s from reset; no compare until full (first DUT_LAT cycles after reset never flag).
- Compare cycle = chk_en & valid-pipe full. g = aligned golden, d = DUT:
  - ready bit: g.ready != d.ready
  - wait bit: g.wait != d.wait
  - wr bit: g.ready & (g.wr != d.wr)
  - rd bit: g.ready & g.wr & d.ready & d.wr & (g.rd != d.rd)
- mismatch/mismatch_fields registered: valid 1 cycle after the compare cycle; 0 in non-compare cycles.
- cycle_count: internal, +1 every clock after reset, wraps at 2^CNT_W.
- First mismatch (err_sticky=0 and any field set): capture first_fields and first_cycle (cycle_count of compare cycle); err_sticky=1 next cycle. Later mismatches do not update first_*.
- err_count +1 per mismatching compare cycle; saturates at all-ones, no wrap.
- chk_clear: next cycle err_sticky, err_fields, first_*, err_count, mismatch, mismatch_fields = 0. Clear beats same-cycle mismatch (dropped). Alignment pipe and cycle_count unaffected.
- chk_en low mid-stream: alignment pipe keeps shifting; only compare suppressed.
- Pass-through outputs are pure wires from gold_*; checker never perturbs the core (except Optional Feature).

Optional Feature:
Macro PCPI_CHK_HALT_EN.
- Defined: extra output chk_halt (1 bit), registered, equal to err_sticky. While chk_halt=1: pcpi_int_wait forced 1, pcpi_int_ready 0, pcpi_int_wr 0, pcpi_int_rd 0, stalling the core at the failing point. Cleared by chk_clear or reset.
- Undefined: no chk_halt port; pass-through always transparent.

Test Plan:
- Reset, DUT_LAT=0, chk_en=1, identical streams for 100 cycles incl. ready&wr rd=0xDEADBEEF -> mismatch, err_sticky, err_count all 0.
- Cycle 20: gold ready=1 wr=1 rd=0x12345678, dut same but rd=0x12345679 -> cycle 21 mismatch=1, mismatch_fields=4'b0010; err_sticky=1; first_cycle=20; err_count=1.
- Gold ready=0, wr differs, rd differs -> no flag (wr/rd qualified by ready); then wait differs -> mismatch_fields=4'b0100.
- DUT_LAT=2, DUT stream = golden delayed 2 cycles -> zero mismatches incl. cycles 0-1; DUT delayed 1 -> flags from first transition.
- CNT_W=4, 20 consecutive mismatches -> err_count=15 saturated; chk_clear with simultaneous mismatch -> next cycle all diagnostics 0, err_count 0.
- PCPI_CHK_HALT_EN: force ready mismatch at cycle 10 -> chk_halt=1 from cycle 12, pcpi_int_wait=1, pcpi_int_ready=0 regardless of gold; chk_clear releases.
